// File: rtl/tt_vector_player.sv
// Vector replay engine for a Tiny Tapeout style pin interface: loads stimulus/expect
// vectors, resets the DUT, replays each vector for HOLD cycles and scores masked uo_out.
module tt_vector_player #(
  parameter int DEPTH      = 16,
  parameter int HOLD       = 4,
  parameter int RST_CYCLES = 8,
  parameter int CW         = 8,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [31:0]   wr_data,
  input  logic          clear,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [CW-1:0] err_count,
  output logic [AW-1:0] first_fail,
  output logic [AW:0]   vec_count,
  output logic [7:0]    dut_ui_in,
  output logic [7:0]    dut_uio_in,
  input  logic [7:0]    dut_uo_out,
  output logic          dut_ena,
  output logic          dut_rst_n
);

  localparam int CMAX = (HOLD > RST_CYCLES) ? HOLD : RST_CYCLES;
  localparam int CNTW = $clog2(CMAX + 1);
  localparam logic [CNTW-1:0] HOLD_LAST = CNTW'(HOLD - 1);
  localparam logic [CNTW-1:0] RST_LAST  = CNTW'(RST_CYCLES - 1);
  localparam logic [AW:0]     DEPTH_V   = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RESET, S_APPLY, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [AW-1:0]   idx_inc;
  logic [AW:0]     vec_count_q, vec_count_d;
  logic [31:0]     vec_q, vec_d;
  logic            cmp_vld_q, cmp_vld_d;
  logic            cmp_last_q, cmp_last_d;
  logic [7:0]      uo_cap_q, uo_cap_d;
  logic [7:0]      cmp_exp_q, cmp_exp_d;
  logic [7:0]      cmp_mask_q, cmp_mask_d;
  logic [AW-1:0]   cmp_idx_q, cmp_idx_d;
  logic [CW-1:0]   err_q, err_d;
  logic [AW-1:0]   first_fail_q, first_fail_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;
  logic            busy_q, busy_d;
  logic            wr_ready_q, wr_ready_d;
  logic            ena_q, ena_d;
  logic            rst_n_q, rst_n_d;
  logic            wr_en;
  logic            mismatch;
  logic            last_vec;

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[vec_count_q[AW-1:0]] <= wr_data;
    end
  end

  assign idx_inc  = idx_q + 1'b1;
  assign last_vec = ({1'b0, idx_q} == (vec_count_q - 1'b1));
  // The compare runs one cycle behind the capture so it overlaps the next vector.
  assign mismatch = |((uo_cap_q ^ cmp_exp_q) & cmp_mask_q);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    vec_count_d  = vec_count_q;
    vec_d        = vec_q;
    cmp_vld_d    = 1'b0;
    cmp_last_d   = cmp_last_q;
    uo_cap_d     = uo_cap_q;
    cmp_exp_d    = cmp_exp_q;
    cmp_mask_d   = cmp_mask_q;
    cmp_idx_d    = cmp_idx_q;
    err_d        = err_q;
    first_fail_d = first_fail_q;
    done_d       = done_q;
    pass_d       = pass_q;
    busy_d       = busy_q;
    ena_d        = ena_q;
    rst_n_d      = rst_n_q;
    wr_en        = 1'b0;

    if (cmp_vld_q && mismatch) begin
      if (err_q == '0) first_fail_d = cmp_idx_q;
      if (err_q != {CW{1'b1}}) err_d = err_q + 1'b1;
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (clear) begin
          vec_count_d  = '0;
          err_d        = '0;
          first_fail_d = '0;
          done_d       = 1'b0;
          pass_d       = 1'b0;
          ena_d        = 1'b0;
          state_d      = S_IDLE;
        end else begin
          if (wr_valid && wr_ready_q) begin
            wr_en       = 1'b1;
            vec_count_d = vec_count_q + 1'b1;
          end
          if (start) begin
            err_d        = '0;
            first_fail_d = '0;
            done_d       = 1'b0;
            pass_d       = 1'b0;
            // An empty store finishes immediately without touching the DUT reset.
            if (vec_count_d == '0) begin
              state_d = S_DONE;
              done_d  = 1'b1;
              pass_d  = 1'b1;
            end else begin
              state_d    = S_RESET;
              busy_d     = 1'b1;
              cnt_d      = '0;
              rst_n_d    = 1'b0;
              ena_d      = 1'b1;
              vec_d      = '0;
              cmp_last_d = 1'b0;
            end
          end
        end
      end
      S_RESET: begin
        if (cnt_q == RST_LAST) begin
          state_d = S_APPLY;
          cnt_d   = '0;
          idx_d   = '0;
          vec_d   = mem[0];
          rst_n_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_APPLY: begin
        if (cmp_last_q) begin
          state_d    = S_DONE;
          cmp_last_d = 1'b0;
          busy_d     = 1'b0;
          done_d     = 1'b1;
          pass_d     = (err_d == '0);
        end else if (cnt_q == HOLD_LAST) begin
          cmp_vld_d  = 1'b1;
          uo_cap_d   = dut_uo_out;
          cmp_exp_d  = vec_q[15:8];
          cmp_mask_d = vec_q[7:0];
          cmp_idx_d  = idx_q;
          cnt_d      = '0;
          if (last_vec) begin
            cmp_last_d = 1'b1;
          end else begin
            idx_d = idx_inc;
            vec_d = mem[idx_inc];
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    wr_ready_d = ((state_d == S_IDLE) || (state_d == S_DONE)) && (vec_count_d < DEPTH_V);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      vec_count_q  <= '0;
      vec_q        <= '0;
      cmp_vld_q    <= 1'b0;
      cmp_last_q   <= 1'b0;
      uo_cap_q     <= '0;
      cmp_exp_q    <= '0;
      cmp_mask_q   <= '0;
      cmp_idx_q    <= '0;
      err_q        <= '0;
      first_fail_q <= '0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      busy_q       <= 1'b0;
      wr_ready_q   <= 1'b1;
      ena_q        <= 1'b0;
      rst_n_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      vec_count_q  <= vec_count_d;
      vec_q        <= vec_d;
      cmp_vld_q    <= cmp_vld_d;
      cmp_last_q   <= cmp_last_d;
      uo_cap_q     <= uo_cap_d;
      cmp_exp_q    <= cmp_exp_d;
      cmp_mask_q   <= cmp_mask_d;
      cmp_idx_q    <= cmp_idx_d;
      err_q        <= err_d;
      first_fail_q <= first_fail_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      busy_q       <= busy_d;
      wr_ready_q   <= wr_ready_d;
      ena_q        <= ena_d;
      rst_n_q      <= rst_n_d;
    end
  end

  assign wr_ready   = wr_ready_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_count  = err_q;
  assign first_fail = first_fail_q;
  assign vec_count  = vec_count_q;
  assign dut_ui_in  = vec_q[31:24];
  assign dut_uio_in = vec_q[23:16];
  assign dut_ena    = ena_q;
  assign dut_rst_n  = rst_n_q;

endmodule
